// File: rtl/dmem_responder_if.sv
// Request/response bundle between the core's data port and the data memory.
// master = core side (drives requests, accepts responses); slave = memory side.
// Ports: req_valid/req_ready handshake with we/addr/size/unsigned/wdata;
//        rsp_valid/rsp_ready handshake with rdata/err.
interface dmem_responder_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [31:0]           req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [31:0]           rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Purpose: byte-addressed little-endian data memory serving sized loads/stores, flags misaligned/illegal-size accesses.
// Latency: response valid WAIT_CYCLES+1 edges after acceptance; one transaction in flight, WAIT_CYCLES+2 cycles each minimum.
// Backpressure: response held stable until rsp_ready; req_ready stays low from acceptance until the response handshake.
// Ports: clk, rst_n (async active-low), bus (dmem_responder_if.slave: request + response channels).
module dmem_responder #(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_responder_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    typedef struct packed {
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [1:0]            size;
        logic                  uns;
        logic [31:0]           wdata;
    } req_t;

    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam bit         NO_WAIT  = (WAIT_CYCLES == 0);

    logic [7:0] mem [2**ADDR_WIDTH];

    state_t      state;
    logic [3:0]  cnt;
    req_t        lat;
    logic        req_ready_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;

    req_t                  live;
    req_t                  cur;
    logic                  accept;
    logic                  exec;
    logic                  acc_err;
    logic [ADDR_WIDTH-1:0] a1, a2, a3;
    logic [7:0]            b0, b1, b2, b3;
    logic [31:0]           ld_ext;
    logic [31:0]           rd_res;

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

    assign accept = bus.req_valid && req_ready_q;
    // With no wait states the access executes on the acceptance edge itself,
    // so the operands come straight from the request bus in IDLE.
    assign exec   = (accept && NO_WAIT) || (state == WAIT && cnt == 4'd0);

    always_comb begin
        live.we    = bus.req_we;
        live.addr  = bus.req_addr;
        live.size  = bus.req_size;
        live.uns   = bus.req_unsigned;
        live.wdata = bus.req_wdata;
        cur        = (state == IDLE) ? live : lat;
    end

    always_comb begin
        acc_err = 1'b0;
        case (cur.size)
            2'b01:   acc_err = cur.addr[0];
            2'b10:   acc_err = |cur.addr[1:0];
            2'b11:   acc_err = 1'b1;
            default: acc_err = 1'b0;
        endcase
    end

    // Aligned legal accesses never cross the top of memory, so the wrapping
    // adds below only matter for addresses whose access is already an error.
    assign a1 = cur.addr + ADDR_WIDTH'(1);
    assign a2 = cur.addr + ADDR_WIDTH'(2);
    assign a3 = cur.addr + ADDR_WIDTH'(3);
    assign b0 = mem[cur.addr];
    assign b1 = mem[a1];
    assign b2 = mem[a2];
    assign b3 = mem[a3];

    always_comb begin
        ld_ext = 32'd0;
        case (cur.size)
            2'b00:   ld_ext = cur.uns ? {24'd0, b0} : {{24{b0[7]}}, b0};
            2'b01:   ld_ext = cur.uns ? {16'd0, b1, b0} : {{16{b1[7]}}, b1, b0};
            2'b10:   ld_ext = {b3, b2, b1, b0};
            default: ld_ext = 32'd0;
        endcase
        rd_res = (acc_err || cur.we) ? 32'd0 : ld_ext;
    end

    // Storage is intentionally not reset; writes happen only on the execute edge.
    always_ff @(posedge clk) begin
        if (exec && cur.we && !acc_err) begin
            mem[cur.addr] <= cur.wdata[7:0];
            if (cur.size != 2'b00) begin
                mem[a1] <= cur.wdata[15:8];
            end
            if (cur.size == 2'b10) begin
                mem[a2] <= cur.wdata[23:16];
                mem[a3] <= cur.wdata[31:24];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            lat         <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat         <= live;
                        req_ready_q <= 1'b0;
                        if (NO_WAIT) begin
                            state       <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= rd_res;
                            rsp_err_q   <= acc_err;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state       <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= rd_res;
                        rsp_err_q   <= acc_err;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state       <= IDLE;
                        req_ready_q <= 1'b1;
                        rsp_valid_q <= 1'b0;
                        rsp_rdata_q <= 32'd0;
                        rsp_err_q   <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (WAIT_CYCLES 1, 3, 0) sharing one clock.
// Expected responses are queued when a request is driven and checked by a
// negedge monitor when the response handshake is about to complete.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        rst_n        [3];
    logic        req_valid    [3];
    logic        req_ready    [3];
    logic        req_we       [3];
    logic [7:0]  req_addr     [3];
    logic [1:0]  req_size     [3];
    logic        req_unsigned [3];
    logic [31:0] req_wdata    [3];
    logic        rsp_valid    [3];
    logic        rsp_ready    [3];
    logic [31:0] rsp_rdata    [3];
    logic        rsp_err      [3];

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int W = (g == 0) ? 1 : (g == 1) ? 3 : 0;
        dmem_responder_if #(.ADDR_WIDTH(8)) bus ();
        assign bus.req_valid    = req_valid[g];
        assign bus.req_we       = req_we[g];
        assign bus.req_addr     = req_addr[g];
        assign bus.req_size     = req_size[g];
        assign bus.req_unsigned = req_unsigned[g];
        assign bus.req_wdata    = req_wdata[g];
        assign bus.rsp_ready    = rsp_ready[g];
        assign req_ready[g]     = bus.req_ready;
        assign rsp_valid[g]     = bus.rsp_valid;
        assign rsp_rdata[g]     = bus.rsp_rdata;
        assign rsp_err[g]       = bus.rsp_err;
        dmem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(W)) dut (
            .clk   (clk),
            .rst_n (rst_n[g]),
            .bus   (bus.slave)
        );
    end

    function automatic int wc(input int d);
        return (d == 0) ? 1 : (d == 1) ? 3 : 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer: a response is taken on the edge following a negedge
    // at which both rsp_valid and rsp_ready are high.
    initial forever begin
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            if (rsp_valid[d] && rsp_ready[d]) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 32'(rsp_valid[d]), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rsp_rdata", rsp_rdata[d], e.rdata);
                    chk("rsp_err", 32'(rsp_err[d]), 32'(e.err));
                end
            end
        end
    end

    // One transaction on instance d. hold>0 keeps rsp_ready low for that many
    // cycles after rsp_valid rises while a competing store to 0x08 is offered.
    // abort asserts reset one cycle after acceptance.
    task automatic xact(input int d, input bit we, input logic [7:0] addr, input logic [1:0] size,
                        input bit uns, input logic [31:0] wdata, input logic [31:0] exp_rd,
                        input bit exp_err, input int hold, input bit abort,
                        output int acc_cyc, output int hs_cyc);
        int   n;
        exp_t e;
        acc_cyc = 0;
        hs_cyc  = 0;
        e.err   = exp_err;
        e.rdata = exp_rd;
        exp_q.push_back(e);
        rsp_ready[d]    = (hold == 0);
        req_valid[d]    = 1'b1;
        req_we[d]       = we;
        req_addr[d]     = addr;
        req_size[d]     = size;
        req_unsigned[d] = uns;
        req_wdata[d]    = wdata;
        n = 0;
        while (!req_ready[d] && n < 40) begin
            step();
            n++;
        end
        if (!req_ready[d]) begin
            chk("accept_timeout", 32'(req_ready[d]), 32'd1);
            req_valid[d] = 1'b0;
            exp_q.delete();
            return;
        end
        step();
        acc_cyc      = cyc;
        req_valid[d] = 1'b0;
        if (abort) begin
            step();
            rst_n[d] = 1'b0;
            #1;
            chk("rst_rsp_valid", 32'(rsp_valid[d]), 32'd0);
            chk("rst_req_ready", 32'(req_ready[d]), 32'd1);
            exp_q.delete();
            step();
            rst_n[d] = 1'b1;
            return;
        end
        n = 0;
        while (!rsp_valid[d] && n < 40) begin
            step();
            n++;
        end
        // Edges from acceptance to the first edge that sees rsp_valid high.
        chk("rsp_latency", 32'(n + 1), 32'(wc(d) + 1));
        if (!rsp_valid[d]) begin
            exp_q.delete();
            return;
        end
        for (int i = 0; i < hold; i++) begin
            chk("hold_valid", 32'(rsp_valid[d]), 32'd1);
            chk("hold_rdata", rsp_rdata[d], exp_rd);
            chk("hold_err", 32'(rsp_err[d]), 32'(exp_err));
            chk("hold_req_ready", 32'(req_ready[d]), 32'd0);
            req_valid[d] = 1'b1;
            req_we[d]    = 1'b1;
            req_addr[d]  = 8'h08;
            req_size[d]  = 2'b10;
            req_wdata[d] = 32'd0;
            step();
        end
        req_valid[d] = 1'b0;
        rsp_ready[d] = 1'b1;
        step();
        hs_cyc = cyc;
        chk("post_rsp_valid", 32'(rsp_valid[d]), 32'd0);
        chk("post_rsp_rdata", rsp_rdata[d], 32'd0);
        chk("post_req_ready", 32'(req_ready[d]), 32'd1);
    endtask

    task automatic run(input int d, input bit we, input logic [7:0] addr, input logic [1:0] size,
                       input bit uns, input logic [31:0] wdata, input logic [31:0] exp_rd,
                       input bit exp_err);
        int a, h;
        xact(d, we, addr, size, uns, wdata, exp_rd, exp_err, 0, 1'b0, a, h);
    endtask

    initial begin
        int acc, hs, prev_acc;
        for (int d = 0; d < 3; d++) begin
            rst_n[d]        = 1'b0;
            req_valid[d]    = 1'b0;
            req_we[d]       = 1'b0;
            req_addr[d]     = 8'h00;
            req_size[d]     = 2'b00;
            req_unsigned[d] = 1'b0;
            req_wdata[d]    = 32'd0;
            rsp_ready[d]    = 1'b0;
        end
        repeat (3) step();
        for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;
        step();
        for (int d = 0; d < 3; d++) begin
            chk("reset_req_ready", 32'(req_ready[d]), 32'd1);
            chk("reset_rsp_valid", 32'(rsp_valid[d]), 32'd0);
            chk("reset_rsp_rdata", rsp_rdata[d], 32'd0);
            chk("reset_rsp_err", 32'(rsp_err[d]), 32'd0);
        end

        // WAIT_CYCLES=1: word store/load and byte placement
        run(0, 1'b1, 8'h08, 2'b10, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0);
        run(0, 1'b0, 8'h08, 2'b10, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0);
        run(0, 1'b0, 8'h08, 2'b00, 1'b1, 32'h0, 32'h000000EF, 1'b0);
        run(0, 1'b0, 8'h0B, 2'b00, 1'b1, 32'h0, 32'h000000DE, 1'b0);
        run(0, 1'b1, 8'h0C, 2'b10, 1'b0, 32'h01020304, 32'h0, 1'b0);

        // Sign/zero extension
        run(0, 1'b1, 8'h10, 2'b10, 1'b0, 32'h0080F0FF, 32'h0, 1'b0);
        run(0, 1'b0, 8'h10, 2'b00, 1'b0, 32'h0, 32'hFFFFFFFF, 1'b0);
        run(0, 1'b0, 8'h11, 2'b00, 1'b1, 32'h0, 32'h000000F0, 1'b0);
        run(0, 1'b0, 8'h12, 2'b01, 1'b0, 32'h0, 32'h00000080, 1'b0);
        run(0, 1'b0, 8'h10, 2'b01, 1'b1, 32'h0, 32'h0000F0FF, 1'b0);
        run(0, 1'b1, 8'h14, 2'b01, 1'b0, 32'hFFFF8001, 32'h0, 1'b0);
        run(0, 1'b0, 8'h14, 2'b01, 1'b0, 32'h0, 32'hFFFF8001, 1'b0);

        // Misaligned and illegal-size accesses
        run(0, 1'b0, 8'h05, 2'b01, 1'b0, 32'h0, 32'h0, 1'b1);
        run(0, 1'b0, 8'h0A, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1);
        run(0, 1'b0, 8'h00, 2'b11, 1'b0, 32'h0, 32'h0, 1'b1);
        run(0, 1'b1, 8'h0A, 2'b10, 1'b0, 32'h11111111, 32'h0, 1'b1);
        run(0, 1'b0, 8'h08, 2'b10, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0);
        run(0, 1'b0, 8'h0C, 2'b10, 1'b0, 32'h0, 32'h01020304, 1'b0);

        // Backpressure: 5 cycles of rsp_ready=0 with an ignored store offered
        xact(0, 1'b0, 8'h08, 2'b10, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 5, 1'b0, acc, hs);
        xact(0, 1'b0, 8'h08, 2'b10, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 0, 1'b0, acc, prev_acc);
        chk("bp_next_accept", 32'(acc), 32'(hs + 1));

        // WAIT_CYCLES=3: reset during WAIT discards the pending store
        run(1, 1'b1, 8'h20, 2'b10, 1'b0, 32'h00000000, 32'h0, 1'b0);
        xact(1, 1'b1, 8'h20, 2'b10, 1'b0, 32'h12345678, 32'h0, 1'b0, 0, 1'b1, acc, hs);
        step();
        chk("post_rst_rdata", rsp_rdata[1], 32'd0);
        run(1, 1'b0, 8'h20, 2'b10, 1'b0, 32'h0, 32'h00000000, 1'b0);
        run(1, 1'b1, 8'h24, 2'b10, 1'b0, 32'hCAFEF00D, 32'h0, 1'b0);
        run(1, 1'b0, 8'h26, 2'b01, 1'b1, 32'h0, 32'h0000CAFE, 1'b0);

        // WAIT_CYCLES=0: back-to-back loads every 2 cycles
        run(2, 1'b1, 8'h40, 2'b10, 1'b0, 32'h80FF7F01, 32'h0, 1'b0);
        step();
        xact(2, 1'b0, 8'h40, 2'b10, 1'b0, 32'h0, 32'h80FF7F01, 1'b0, 0, 1'b0, prev_acc, hs);
        xact(2, 1'b0, 8'h42, 2'b00, 1'b0, 32'h0, 32'hFFFFFFFF, 1'b0, 0, 1'b0, acc, hs);
        chk("b2b_spacing1", 32'(acc - prev_acc), 32'd2);
        prev_acc = acc;
        xact(2, 1'b0, 8'h42, 2'b01, 1'b0, 32'h0, 32'hFFFF80FF, 1'b0, 0, 1'b0, acc, hs);
        chk("b2b_spacing2", 32'(acc - prev_acc), 32'd2);
        prev_acc = acc;
        xact(2, 1'b0, 8'h40, 2'b01, 1'b1, 32'h0, 32'h00007F01, 1'b0, 0, 1'b0, acc, hs);
        chk("b2b_spacing3", 32'(acc - prev_acc), 32'd2);

        step();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Byte-addressed data-memory responder that serves the processor's load/store requests over a valid/ready request channel and returns read data or completion status over a valid/ready response channel. It is the memory-side end of the processor's data port: the core initiates, this block holds storage (little-endian byte array), applies a programmable wait-state latency, performs sized and sign-/zero-extended accesses, and flags illegal accesses. It replaces direct array indexing of data memory so the pipeline can be tested against a stalling memory.

## Interface
- ADDR_WIDTH, 8, byte-address width; memory depth is 2^ADDR_WIDTH bytes
- WAIT_CYCLES, 1, wait states between request acceptance and response (0..15)

- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  ADDR_WIDTH  byte address
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  loads: 1 zero-extend, 0 sign-extend
- req_wdata  in  32  store data, low bytes used for byte/half
- rsp_valid  out  1  response present
- rsp_ready  in  1  core accepts response
- rsp_rdata  out  32  load result (extended); 0 for stores and errors
- rsp_err  out  1  access was misaligned or illegal size

## Operation
- FSM states IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, latch we/addr/size/unsigned/wdata; go WAIT if WAIT_CYCLES>0, else execute and go RESP.
- WAIT: req_ready=0; 4-bit counter loaded with WAIT_CYCLES-1 on accept, decrements each cycle; at 0 execute access and go RESP.
- RESP: rsp_valid=1, rsp_rdata/rsp_err stable; on rsp_ready go IDLE. Inputs on req_* ignored outside IDLE.
- Execute (single edge, commit point): error if size==11, or size==01 and addr[0]!=0, or size==10 and addr[1:0]!=0. Error: no memory write, rdata=0, err=1.
- Store: write bytes addr..addr+N-1 with wdata[8N-1:0], byte at addr = wdata[7:0]; rdata=0, err=0.
- Load: assemble little-endian {mem[addr+3],..,mem[addr]} for N bytes; extend bit 8N-1 (signed) or zeros (unsigned) to 32 bits.
- Address arithmetic stays within ADDR_WIDTH; aligned accesses never wrap, so no wrap case exists for legal requests.
- Memory array is not cleared by reset; simulation initial contents 0.

## Timing
- Reset values: req_ready=1 after reset release (0 while rst_n=0 is not required; drive 1 in IDLE), rsp_valid=0, rsp_rdata=0, rsp_err=0, FSM=IDLE, counter=0.
- Request accepted on edge T0; rsp_valid rises after edge T0+WAIT_CYCLES+1 and holds until the edge where rsp_ready=1.
- rsp_ready may already be high when rsp_valid rises; handshake completes that edge, req_ready=1 next cycle.
- Throughput: one transaction per WAIT_CYCLES+2 cycles minimum; no pipelining, no outstanding >1.
- Store data visible to a load accepted any time after the store's response handshake.
- Reset asserted mid-transaction: FSM returns IDLE immediately, rsp_valid=0; a store not yet executed is discarded; an executed store remains in memory.
- rsp_rdata/rsp_err change only on execute edge and are zeroed on leaving RESP.

## Test plan
- WAIT_CYCLES=1: store word 0xDEADBEEF at 0x08, then load word 0x08 -> rsp_rdata=0xDEADBEEF, rsp_valid 2 cycles after accept, err=0; mem[8]=0xEF, mem[11]=0xDE.
- Byte/half extension: store word 0x0080F0FF at 0x10; load byte signed 0x10 -> 0xFFFFFFFF; byte unsigned 0x11 -> 0x000000F0; half signed 0x12 -> 0x00000080; half unsigned 0x10 -> 0x0000F0FF.
- Errors: load half at 0x05, word at 0x0A, size=11 at 0x00 -> err=1, rdata=0; store word 0x11111111 at 0x0A then aligned loads 0x08/0x0C unchanged.
- Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid, rdata, err stable, req_ready=0, new req_valid ignored; release -> next request accepted the following cycle.
- Reset mid-WAIT with WAIT_CYCLES=3: store 0x12345678 at 0x20, assert rst_n=0 one cycle after accept -> rsp_valid=0, later load 0x20 returns prior value (0).
- WAIT_CYCLES=0 back-to-back with rsp_ready=1: 4 loads accepted every 2 cycles, each rsp_valid exactly 1 cycle after accept.
